// File: rtl/reservation_station_pkg.sv
// Shared widths and ALU op-codes for the reservation station and its neighbours.
// Default sizes match the 8-entry RS / 16-entry ROB configuration.
package reservation_station_pkg;

    localparam int DEF_RS_SIZE_BIT  = 3;
    localparam int DEF_ROB_SIZE_BIT = 4;
    localparam int DEF_ALU_OP_BIT   = 5;
    localparam int XLEN             = 32;

    typedef enum logic [DEF_ALU_OP_BIT-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_SLL  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_SLT  = 5'd8,
        ALU_SLTU = 5'd9,
        ALU_BEQ  = 5'd10,
        ALU_BNE  = 5'd11,
        ALU_BLT  = 5'd12,
        ALU_BGE  = 5'd13,
        ALU_BLTU = 5'd14,
        ALU_BGEU = 5'd15
    } alu_op_e;

endpackage

// File: rtl/reservation_station_first_one.sv
// Lowest-index priority encoder: found=|vec, idx=position of the lowest set bit.
// Purely combinational; no flow control.
module rs_first_one #(
    parameter int W     = 8,
    parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     vec,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Scan downward so the last hit written is the lowest index.
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: issue to dispatch takes 2 edges minimum (write edge, then select edge).
// Backpressure: full is combinational on busy bits only; rdy_in=0 freezes everything.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE_BIT = DEF_RS_SIZE_BIT,
    parameter int ROB_IDX_W   = DEF_ROB_SIZE_BIT,
    parameter int OP_W        = DEF_ALU_OP_BIT
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,

    input  logic                 iss_valid,
    input  logic [OP_W-1:0]      iss_op,
    input  logic [31:0]          iss_vj,
    input  logic [31:0]          iss_vk,
    input  logic                 iss_has_qj,
    input  logic                 iss_has_qk,
    input  logic [ROB_IDX_W-1:0] iss_qj,
    input  logic [ROB_IDX_W-1:0] iss_qk,
    input  logic [ROB_IDX_W-1:0] iss_rob_idx,
    output logic                 full,

    input  logic                 alu_wb_valid,
    input  logic [ROB_IDX_W-1:0] alu_wb_idx,
    input  logic [31:0]          alu_wb_value,
    input  logic                 lsb_wb_valid,
    input  logic [ROB_IDX_W-1:0] lsb_wb_idx,
    input  logic [31:0]          lsb_wb_value,

    output logic                 ex_valid,
    output logic [OP_W-1:0]      ex_op,
    output logic [31:0]          ex_v1,
    output logic [31:0]          ex_v2,
    output logic [ROB_IDX_W-1:0] ex_rob_idx
);

    localparam int N = 1 << RS_SIZE_BIT;

    typedef struct packed {
        logic                 busy;
        logic [OP_W-1:0]      op;
        logic [31:0]          vj;
        logic [31:0]          vk;
        logic [ROB_IDX_W-1:0] qj;
        logic [ROB_IDX_W-1:0] qk;
        logic                 has_qj;
        logic                 has_qk;
        logic [ROB_IDX_W-1:0] rob_idx;
    } entry_t;

    entry_t ent_q [N];
    entry_t ent_d [N];
    entry_t new_ent;

    logic [N-1:0]             busy_vec;
    logic [N-1:0]             ready_vec;
    logic                     free_found;
    logic [RS_SIZE_BIT-1:0]   free_idx;
    logic                     disp_found;
    logic [RS_SIZE_BIT-1:0]   disp_idx;
    logic                     issue_fire;

    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < N; i++) begin
            busy_vec[i]  = ent_q[i].busy;
            ready_vec[i] = ent_q[i].busy & ~ent_q[i].has_qj & ~ent_q[i].has_qk;
        end
    end

    rs_first_one #(.W(N), .IDX_W(RS_SIZE_BIT)) u_free_sel (
        .vec   (~busy_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_first_one #(.W(N), .IDX_W(RS_SIZE_BIT)) u_disp_sel (
        .vec   (ready_vec),
        .found (disp_found),
        .idx   (disp_idx)
    );

    // A dispatch in the same cycle does not free a slot until the next one.
    assign full       = ~free_found;
    assign issue_fire = iss_valid & free_found;

    // Incoming instruction, with same-cycle write-back bypass (ALU bus wins).
    always_comb begin
        new_ent         = '0;
        new_ent.busy    = 1'b1;
        new_ent.op      = iss_op;
        new_ent.qj      = iss_qj;
        new_ent.qk      = iss_qk;
        new_ent.rob_idx = iss_rob_idx;
        new_ent.vj      = iss_vj;
        new_ent.vk      = iss_vk;
        new_ent.has_qj  = iss_has_qj;
        new_ent.has_qk  = iss_has_qk;
        if (iss_has_qj && alu_wb_valid && iss_qj == alu_wb_idx) begin
            new_ent.vj     = alu_wb_value;
            new_ent.has_qj = 1'b0;
        end else if (iss_has_qj && lsb_wb_valid && iss_qj == lsb_wb_idx) begin
            new_ent.vj     = lsb_wb_value;
            new_ent.has_qj = 1'b0;
        end
        if (iss_has_qk && alu_wb_valid && iss_qk == alu_wb_idx) begin
            new_ent.vk     = alu_wb_value;
            new_ent.has_qk = 1'b0;
        end else if (iss_has_qk && lsb_wb_valid && iss_qk == lsb_wb_idx) begin
            new_ent.vk     = lsb_wb_value;
            new_ent.has_qk = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].busy && ent_q[i].has_qj) begin
                if (alu_wb_valid && ent_q[i].qj == alu_wb_idx) begin
                    ent_d[i].vj     = alu_wb_value;
                    ent_d[i].has_qj = 1'b0;
                end else if (lsb_wb_valid && ent_q[i].qj == lsb_wb_idx) begin
                    ent_d[i].vj     = lsb_wb_value;
                    ent_d[i].has_qj = 1'b0;
                end
            end
            if (ent_q[i].busy && ent_q[i].has_qk) begin
                if (alu_wb_valid && ent_q[i].qk == alu_wb_idx) begin
                    ent_d[i].vk     = alu_wb_value;
                    ent_d[i].has_qk = 1'b0;
                end else if (lsb_wb_valid && ent_q[i].qk == lsb_wb_idx) begin
                    ent_d[i].vk     = lsb_wb_value;
                    ent_d[i].has_qk = 1'b0;
                end
            end
        end
        // Dispatch slot and issue slot never coincide: one is busy, the other free.
        if (disp_found) begin
            ent_d[disp_idx].busy = 1'b0;
        end
        if (issue_fire) begin
            ent_d[free_idx] = new_ent;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < N; i++) begin
                ent_q[i] <= '0;
            end
            ex_valid   <= 1'b0;
            ex_op      <= '0;
            ex_v1      <= '0;
            ex_v2      <= '0;
            ex_rob_idx <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                for (int i = 0; i < N; i++) begin
                    ent_q[i].busy <= 1'b0;
                end
                ex_valid <= 1'b0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    ent_q[i] <= ent_d[i];
                end
                ex_valid <= disp_found;
                if (disp_found) begin
                    ex_op      <= ent_q[disp_idx].op;
                    ex_v1      <= ent_q[disp_idx].vj;
                    ex_v2      <= ent_q[disp_idx].vk;
                    ex_rob_idx <= ent_q[disp_idx].rob_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench: expected dispatches are queued with their due cycle and checked as they appear.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic        iss_valid;
    logic [4:0]  iss_op;
    logic [31:0] iss_vj, iss_vk;
    logic        iss_has_qj, iss_has_qk;
    logic [3:0]  iss_qj, iss_qk, iss_rob_idx;
    logic        full;
    logic        alu_wb_valid;
    logic [3:0]  alu_wb_idx;
    logic [31:0] alu_wb_value;
    logic        lsb_wb_valid;
    logic [3:0]  lsb_wb_idx;
    logic [31:0] lsb_wb_value;
    logic        ex_valid;
    logic [4:0]  ex_op;
    logic [31:0] ex_v1, ex_v2;
    logic [3:0]  ex_rob_idx;

    reservation_station dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .iss_valid(iss_valid), .iss_op(iss_op), .iss_vj(iss_vj), .iss_vk(iss_vk),
        .iss_has_qj(iss_has_qj), .iss_has_qk(iss_has_qk), .iss_qj(iss_qj), .iss_qk(iss_qk),
        .iss_rob_idx(iss_rob_idx), .full(full),
        .alu_wb_valid(alu_wb_valid), .alu_wb_idx(alu_wb_idx), .alu_wb_value(alu_wb_value),
        .lsb_wb_valid(lsb_wb_valid), .lsb_wb_idx(lsb_wb_idx), .lsb_wb_value(lsb_wb_value),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_v1(ex_v1), .ex_v2(ex_v2), .ex_rob_idx(ex_rob_idx)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [3:0]  rob;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   vec  = 0;
    int   miss = 0;
    int   cyc  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vec++;
        assert (obs === expv) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [4:0] op, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [3:0] rob, input int due);
        exp_t e;
        e.op = op; e.v1 = v1; e.v2 = v2; e.rob = rob; e.cyc = due;
        sb.push_back(e);
    endtask

    task automatic step_raw();
        @(posedge clk_in);
        cyc++;
        #1;
    endtask

    task automatic step();
        exp_t e;
        step_raw();
        if (sb.size() != 0 && sb[0].cyc < cyc) begin
            miss++;
            vec++;
            $error("FAIL missed_dispatch observed=none expected=rob%0d@cycle%0d", sb[0].rob, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (ex_valid === 1'b1) begin
            chk("unexpected_dispatch", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("dispatch_cycle", cyc, e.cyc);
                chk("ex_op", 32'(ex_op), 32'(e.op));
                chk("ex_v1", ex_v1, e.v1);
                chk("ex_v2", ex_v2, e.v2);
                chk("ex_rob_idx", 32'(ex_rob_idx), 32'(e.rob));
            end
        end else begin
            chk("ex_valid_low", 32'(ex_valid), 32'd0);
        end
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_has_qj = 1'b0; iss_has_qk = 1'b0;
        alu_wb_valid = 1'b0; lsb_wb_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic hqj, input logic [3:0] qj,
                         input logic hqk, input logic [3:0] qk, input logic [3:0] rob);
        iss_valid = 1'b1; iss_op = op; iss_vj = vj; iss_vk = vk;
        iss_has_qj = hqj; iss_qj = qj; iss_has_qk = hqk; iss_qk = qk; iss_rob_idx = rob;
    endtask

    task automatic alu_wb(input logic [3:0] idx, input logic [31:0] val);
        alu_wb_valid = 1'b1; alu_wb_idx = idx; alu_wb_value = val;
    endtask

    task automatic lsb_wb(input logic [3:0] idx, input logic [31:0] val);
        lsb_wb_valid = 1'b1; lsb_wb_idx = idx; lsb_wb_value = val;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 4; i++) step();
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1;
        iss_op = '0; iss_vj = '0; iss_vk = '0; iss_qj = '0; iss_qk = '0; iss_rob_idx = '0;
        alu_wb_idx = '0; alu_wb_value = '0; lsb_wb_idx = '0; lsb_wb_value = '0;
        idle();
        #2;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ex_op", 32'(ex_op), 32'd0);
        chk("rst_ex_v1", ex_v1, 32'd0);
        chk("rst_ex_v2", ex_v2, 32'd0);
        chk("rst_ex_rob", 32'(ex_rob_idx), 32'd0);
        rst_in = 1'b1;
        step();

        // Ready issue: visible two edges after being driven.
        issue(ALU_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2);
        step();
        push(ALU_ADD, 32'd5, 32'd7, 4'd2, cyc + 1);
        idle();
        drain("ready_issue_drain");

        // Wakeup via ALU bus.
        issue(ALU_SUB, 32'd0, 32'd1, 1'b1, 4'd3, 1'b0, 4'd0, 4'd5);
        step();
        idle();
        step();
        alu_wb(4'd3, 32'h10);
        step();
        push(ALU_SUB, 32'h10, 32'd1, 4'd5, cyc + 1);
        idle();
        drain("wakeup_drain");

        // Same-cycle bypass from LSB bus, then ALU-over-LSB priority at issue.
        issue(ALU_AND, 32'd9, 32'd0, 1'b0, 4'd0, 1'b1, 4'd4, 4'd6);
        lsb_wb(4'd4, 32'hABCD);
        step();
        push(ALU_AND, 32'd9, 32'hABCD, 4'd6, cyc + 1);
        idle();
        issue(ALU_SRL, 32'd0, 32'd2, 1'b1, 4'd6, 1'b0, 4'd0, 4'd10);
        alu_wb(4'd6, 32'h600);
        lsb_wb(4'd6, 32'h601);
        step();
        push(ALU_SRL, 32'h600, 32'd2, 4'd10, cyc + 1);
        idle();
        drain("bypass_drain");

        // Both buses wake different operands; then ALU priority on wakeup.
        issue(ALU_OR, 32'd0, 32'd0, 1'b1, 4'd2, 1'b1, 4'd3, 4'd7);
        step();
        issue(ALU_XOR, 32'd0, 32'd5, 1'b1, 4'd7, 1'b0, 4'd0, 4'd8);
        step();
        idle();
        alu_wb(4'd2, 32'h22);
        lsb_wb(4'd3, 32'h33);
        step();
        push(ALU_OR, 32'h22, 32'h33, 4'd7, cyc + 1);
        alu_wb(4'd7, 32'h70);
        lsb_wb(4'd7, 32'h71);
        step();
        push(ALU_XOR, 32'h70, 32'd5, 4'd8, cyc + 1);
        idle();
        drain("dual_wake_drain");

        // Fill all 8 entries on tag 1, broadcast, expect in-order dispatch.
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("not_full_at_7", 32'(full), 32'd0);
            issue(ALU_ADD, 32'd0, 32'(i * 3), 1'b1, 4'd1, 1'b0, 4'd0, 4'(i));
            step();
            idle();
        end
        chk("full_set", 32'(full), 32'd1);
        alu_wb(4'd1, 32'h77);
        step();
        idle();
        chk("full_after_wake_edge", 32'(full), 32'd1);
        for (int i = 0; i < 8; i++) push(ALU_ADD, 32'h77, 32'(i * 3), 4'(i), cyc + 1 + i);
        step();
        chk("full_after_first_dispatch", 32'(full), 32'd0);
        for (int i = 0; i < 7; i++) step();
        drain("order_drain");

        // Flush with 5 busy, concurrent ready issue and matching write-back.
        for (int i = 0; i < 5; i++) begin
            issue(ALU_ADD, 32'd0, 32'(i), 1'b1, 4'd9, 1'b0, 4'd0, 4'(i + 1));
            step();
            idle();
        end
        clear = 1'b1;
        issue(ALU_ADD, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd12);
        alu_wb(4'd9, 32'h99);
        step();
        idle();
        chk("full_after_clear", 32'(full), 32'd0);
        alu_wb(4'd9, 32'h99);
        step();
        idle();
        drain("flush_drain");

        // Stall: rdy_in low holds ex_* with a ready entry pending.
        issue(ALU_SLT, 32'h55, 32'h66, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
        step();
        push(ALU_SLT, 32'h55, 32'h66, 4'd3, cyc + 1);
        issue(ALU_SLTU, 32'h11, 32'h22, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4);
        step();
        idle();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_raw();
            chk("stall_ex_valid", 32'(ex_valid), 32'd1);
            chk("stall_ex_v1", ex_v1, 32'h55);
            chk("stall_ex_rob", 32'(ex_rob_idx), 32'd3);
        end
        rdy_in = 1'b1;
        push(ALU_SLTU, 32'h11, 32'h22, 4'd4, cyc + 1);
        step();
        drain("stall_drain");

        // Async reset mid-run with 3 waiting entries and a live dispatch.
        for (int i = 0; i < 3; i++) begin
            issue(ALU_ADD, 32'd0, 32'd0, 1'b1, 4'd11, 1'b0, 4'd0, 4'(i));
            step();
            idle();
        end
        issue(ALU_ADD, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
        step();
        push(ALU_ADD, 32'd3, 32'd4, 4'd9, cyc + 1);
        idle();
        step();
        #1 rst_in = 1'b0;
        #1;
        chk("midrst_ex_valid", 32'(ex_valid), 32'd0);
        chk("midrst_full", 32'(full), 32'd0);
        chk("midrst_ex_v1", ex_v1, 32'd0);
        chk("midrst_ex_rob", 32'(ex_rob_idx), 32'd0);
        rst_in = 1'b1;
        alu_wb(4'd11, 32'hBB);
        step();
        idle();
        drain("reset_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
